// File: rtl/gmii_frame_checker.sv
// ---------------------------------------------------------------------------
// gmii_frame_checker
//
// Watches a GMII byte stream and does three things:
//   - strips the preamble and SFD,
//   - forwards the frame payload on a simple AXI-Stream master (no tready),
//     holding back the last four bytes so the FCS is never emitted,
//   - checks each frame and reports the result as status pulses and
//     saturating good/bad counters.
//
// A frame is bad if it has GMII errors in the payload, is shorter than
// MIN_FRAME_LENGTH, or fails the CRC-32 check. A frame longer than
// MAX_FRAME_LENGTH is cut off: it is closed early with tuser=1 and the rest
// is dropped.
//
// Parameters
//   MIN_FRAME_LENGTH : smallest good frame in bytes, SFD excluded, FCS included
//   MAX_FRAME_LENGTH : largest allowed frame in bytes, FCS included
//
// Ports
//   clk, rst_n       : single clock, asynchronous active-low reset
//   gmii_rxd         : GMII data byte
//   gmii_rx_dv       : GMII data valid
//   gmii_rx_er       : GMII error
//   cfg_enable       : checker enable, only looked at when a frame starts
//   m_axis_tdata     : payload byte
//   m_axis_tvalid    : payload byte valid
//   m_axis_tlast     : last payload byte of the frame
//   m_axis_tuser     : bad-frame flag, only meaningful with tlast
//   stat_good_frame  : one-cycle pulse for each good frame
//   stat_bad_frame   : one-cycle pulse for each bad frame
//   stat_bad_fcs     : one-cycle pulse, together with stat_bad_frame, on CRC error
//   good_cnt         : saturating count of good frames
//   bad_cnt          : saturating count of bad frames
// ---------------------------------------------------------------------------
module gmii_frame_checker #(
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int MAX_FRAME_LENGTH = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic        cfg_enable,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        stat_good_frame,
  output logic        stat_bad_frame,
  output logic        stat_bad_fcs,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    WAIT_END
  } state_t;

  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  // Running the register over payload plus a correct FCS always leaves this
  // residue, so there is no need to compare against the received FCS bytes.
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;
  localparam logic [11:0] LEN_SAT      = 12'hFFF;
  localparam logic [12:0] OVERSIZE_LEN = 13'(MAX_FRAME_LENGTH + 1);
  localparam logic [12:0] MIN_LEN      = 13'(MIN_FRAME_LENGTH);
  localparam logic [7:0]  PRE_BYTE     = 8'h55;
  localparam logic [7:0]  SFD_BYTE     = 8'hD5;

  // Byte-wide update of the reflected CRC-32 register.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Registered copy of the GMII inputs.
  logic [7:0] rxd_q;
  logic       dv_q;
  logic       er_q;
  // Marks that rxd_q/dv_q/er_q hold a real sample rather than reset values.
  logic       in_valid_q;

  // Frame state.
  state_t          state;
  logic [31:0]     crc;
  logic [11:0]     len;
  logic            err_flag;
  logic [4:0][7:0] dline;
  // Set on reset. Until it clears, a busy line is treated as an unknown
  // frame and skipped through WAIT_END instead of being decoded.
  logic            sync_pending;

  // Frame verdict, waiting one cycle before it appears as a pulse.
  logic pend_good;
  logic pend_bad;
  logic pend_fcs;

  logic [31:0] crc_next;
  logic [11:0] len_inc;
  logic        crc_bad;
  logic        len_short;
  logic        frame_bad;

  assign crc_next  = crc32_byte(crc, rxd_q);
  assign len_inc   = (len == LEN_SAT) ? len : len + 12'd1;
  assign crc_bad   = (crc != CRC_RESIDUE);
  assign len_short = ({1'b0, len} < MIN_LEN);
  assign frame_bad = err_flag | len_short | crc_bad;

  // The GMII inputs go through one register stage before anything else uses
  // them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_q      <= 8'h00;
      dv_q       <= 1'b0;
      er_q       <= 1'b0;
      in_valid_q <= 1'b0;
    end else begin
      rxd_q      <= gmii_rxd;
      dv_q       <= gmii_rx_dv;
      er_q       <= gmii_rx_er;
      in_valid_q <= 1'b1;
    end
  end

  // Frame FSM with the payload datapath, AXIS outputs, status pulses and
  // counters.
  //
  // Payload bytes pass through a five-byte delay line. A byte is emitted only
  // once five newer bytes have arrived, so the four FCS bytes stay in the
  // line when dv drops. The byte still held in the oldest slot then goes out
  // as the tlast beat. The verdict is latched when the frame ends and appears
  // on the status pulses and counters one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      crc             <= CRC_INIT;
      len             <= 12'd0;
      err_flag        <= 1'b0;
      dline           <= '0;
      sync_pending    <= 1'b1;
      pend_good       <= 1'b0;
      pend_bad        <= 1'b0;
      pend_fcs        <= 1'b0;
      m_axis_tdata    <= 8'h00;
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tuser    <= 1'b0;
      stat_good_frame <= 1'b0;
      stat_bad_frame  <= 1'b0;
      stat_bad_fcs    <= 1'b0;
      good_cnt        <= 16'h0000;
      bad_cnt         <= 16'h0000;
    end else begin
      m_axis_tvalid   <= 1'b0;
      m_axis_tlast    <= 1'b0;
      m_axis_tuser    <= 1'b0;
      stat_good_frame <= pend_good;
      stat_bad_frame  <= pend_bad;
      stat_bad_fcs    <= pend_fcs;
      pend_good       <= 1'b0;
      pend_bad        <= 1'b0;
      pend_fcs        <= 1'b0;

      if (pend_good && (good_cnt != 16'hFFFF)) begin
        good_cnt <= good_cnt + 16'd1;
      end
      if (pend_bad && (bad_cnt != 16'hFFFF)) begin
        bad_cnt <= bad_cnt + 16'd1;
      end

      if (in_valid_q) begin
        sync_pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (in_valid_q && dv_q) begin
            if (!sync_pending && (rxd_q == PRE_BYTE) && cfg_enable) begin
              state <= PREAMBLE;
            end else begin
              state <= WAIT_END;
            end
          end
        end

        PREAMBLE: begin
          if (!dv_q) begin
            state <= IDLE;
          end else if (er_q) begin
            state <= WAIT_END;
          end else if (rxd_q == PRE_BYTE) begin
            state <= PREAMBLE;
          end else if (rxd_q == SFD_BYTE) begin
            state    <= PAYLOAD;
            len      <= 12'd0;
            crc      <= CRC_INIT;
            err_flag <= 1'b0;
          end else begin
            state <= WAIT_END;
          end
        end

        PAYLOAD: begin
          if (dv_q) begin
            crc   <= crc_next;
            len   <= len_inc;
            dline <= {dline[3:0], rxd_q};
            if (er_q) begin
              err_flag <= 1'b1;
            end
            if ({1'b0, len_inc} == OVERSIZE_LEN) begin
              // Oversize: close the stream now and drop the rest.
              m_axis_tdata  <= dline[4];
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= 1'b1;
              m_axis_tuser  <= 1'b1;
              pend_bad      <= 1'b1;
              state         <= WAIT_END;
            end else if (len >= 12'd5) begin
              m_axis_tdata  <= dline[4];
              m_axis_tvalid <= 1'b1;
            end
          end else begin
            // End of frame. A frame with fewer than five bytes has no
            // payload byte to emit, so it produces only the status pulse.
            if (len >= 12'd5) begin
              m_axis_tdata  <= dline[4];
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= 1'b1;
              m_axis_tuser  <= frame_bad;
            end
            pend_good <= ~frame_bad;
            pend_bad  <= frame_bad;
            pend_fcs  <= crc_bad;
            state     <= IDLE;
          end
        end

        WAIT_END: begin
          if (!dv_q) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gmii_frame_checker.md
GMII_FRAME_CHECKER -- requirements
Module: gmii_frame_checker

Interface
REQ-001 SHALL have parameter MIN_FRAME_LENGTH, default 64: minimum good frame length in bytes, SFD excluded, FCS included.
REQ-002 SHALL have parameter MAX_FRAME_LENGTH, default 1518: maximum frame length in bytes, FCS included.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port gmii_rxd, input, 8: GMII data byte from the MAC transmit side.
REQ-006 SHALL have port gmii_rx_dv, input, 1: GMII data valid.
REQ-007 SHALL have port gmii_rx_er, input, 1: GMII error.
REQ-008 SHALL have port cfg_enable, input, 1: checker enable, sampled only at frame start.
REQ-009 SHALL have port m_axis_tdata, output, 8: payload byte.
REQ-010 SHALL have port m_axis_tvalid, output, 1: beat valid; there is no tready and no backpressure.
REQ-011 SHALL have port m_axis_tlast, output, 1: last payload byte of the frame.
REQ-012 SHALL have port m_axis_tuser, output, 1: bad-frame flag, meaningful only with tlast.
REQ-013 SHALL have ports stat_good_frame, stat_bad_frame and stat_bad_fcs, output, 1 each: single-cycle status pulses.
REQ-014 SHALL have ports good_cnt and bad_cnt, output, 16 each: saturating frame counters.

Function
REQ-015 SHALL register gmii_rxd, gmii_rx_dv and gmii_rx_er once; all later behaviour uses these registered values.
REQ-016 SHALL use the states IDLE, PREAMBLE, PAYLOAD and WAIT_END.
REQ-017 SHALL, in IDLE, move as follows:
- dv=1, byte 0x55, cfg_enable=1 -> PREAMBLE.
- dv=1, any other case -> WAIT_END.
REQ-018 SHALL, in PREAMBLE, move as follows:
- 0x55 -> stay.
- 0xD5 -> PAYLOAD; clear the length counter; set CRC to 0xFFFFFFFF.
- other byte, or er=1 -> WAIT_END.
- dv=0 -> IDLE.
- No status pulse is produced on any of these paths.
REQ-019 SHALL, in WAIT_END, return to IDLE on the first cycle with dv=0.
REQ-020 SHALL, in PAYLOAD, do the following for each byte with dv=1:
- Update the CRC-32 (reflected polynomial 0xEDB88320, no final XOR).
- Increment the 12-bit length counter, saturating at 4095.
- Shift the byte into a 5-byte delay line.
REQ-021 SHALL present byte D[k] on m_axis (tvalid=1, tlast=0) in the cycle after the edge that samples D[k+5], so the 4 FCS bytes are never emitted.
REQ-022 SHALL treat the first dv=0 in PAYLOAD as end of frame (N = length):
- Next cycle: emit the held byte D[N-5] with tlast=1 and tuser set to the bad flag.
- Next cycle: pulse the status outputs.
- Return to IDLE.
REQ-023 SHALL mark a frame bad if any of the following hold:
- er=1 on any PAYLOAD byte.
- N < MIN_FRAME_LENGTH.
- The final CRC register is not 0xDEBB20E3.
REQ-024 SHALL pulse stat_bad_fcs together with stat_bad_frame on a CRC mismatch.
REQ-025 SHALL pulse stat_bad_frame alone for er or length errors that have a good CRC.
REQ-026 SHALL pulse stat_good_frame otherwise.
REQ-027 SHALL, when N < 5, emit no AXIS beat and pulse stat_bad_frame.
REQ-028 SHALL, when length reaches MAX_FRAME_LENGTH+1, handle the oversize frame as follows:
- Next cycle: emit the held byte with tlast=1 and tuser=1.
- Pulse stat_bad_frame.
- Discard the remaining bytes in WAIT_END.
REQ-029 SHALL increment good_cnt or bad_cnt on the same cycle as the matching pulse, saturating at 0xFFFF.
REQ-030 SHALL keep tvalid=0 during IDLE, PREAMBLE and WAIT_END, except for the tlast beat.
REQ-031 SHALL let a cfg_enable change during a frame take effect only at the next frame start.
REQ-032 SHALL accept a new frame start on the cycle immediately after returning to IDLE; no minimum IFG is enforced.

Reset
REQ-033 SHALL, while rst_n=0, force all of the following to 0:
- State = IDLE.
- All m_axis outputs.
- All stat pulses.
- good_cnt and bad_cnt.
- The delay line.
REQ-034 SHALL discard any partial frame on reset, with no status pulse.
REQ-035 SHALL ignore an in-progress frame on the first cycle after reset release; the checker resynchronises through WAIT_END.

Verification
REQ-036 SHALL cover: 7x0x55, 0xD5, payload 0x00..0x3B (60 bytes), correct FCS -> 60 beats, tlast on 0x3B, tuser=0, one stat_good_frame, good_cnt=1.
REQ-037 SHALL cover: the same frame with the last FCS byte inverted -> 60 beats, tuser=1, stat_bad_fcs and stat_bad_frame pulses, bad_cnt=1.
REQ-038 SHALL cover: the same frame with er=1 on payload byte 10 and a good FCS -> tuser=1, stat_bad_frame only.
REQ-039 SHALL cover: a runt of 3 bytes after SFD -> no beats, stat_bad_frame pulse.
REQ-040 SHALL cover: a 1600-byte frame -> 1514 beats, the last with tlast=1 and tuser=1, one stat_bad_frame; a following good 64-byte frame is then accepted.
REQ-041 SHALL cover: rst_n low mid-payload -> outputs and counters 0, no pulse; after release and the current frame's end, the next good frame gives good_cnt=1.
